pe_simd_drain: RTL and testbench
================================

Name: pe_simd_drain

Overview:
- Next-generation systolic processing element for the Q-projection array.
- Each cycle it takes LANES operand pairs from its left and top neighbours, forwards them one cycle later, and accumulates their dot product into a saturating accumulator.
- Adds a stall enable, valid tagging, signed/unsigned operand mode, bias preload that merges with the first beat, and a double-buffered drain register chained down the column. The next tile therefore accumulates while the previous result shifts out.

Parameters:
- DATA_WIDTH, 8, width of one operand lane.
- ACC_WIDTH, 32, accumulator, bias and drain width.
- LANES, 2, operand pairs multiplied and summed per cycle (1..8).
- SATURATE, 1, 1 = accumulator clamps at signed ACC_WIDTH bounds; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global stall; 0 = every register holds.
- signed_mode  in  1  1 = operands signed, 0 = operands unsigned (zero-extended).
- in_valid  in  1  in_a/in_b beat is valid.
- in_a  in  LANES*DATA_WIDTH  left operands; lane i at bits [i*DW +: DW].
- in_b  in  LANES*DATA_WIDTH  top operands, same packing.
- out_valid  out  1  registered copy of in_valid.
- out_a  out  LANES*DATA_WIDTH  registered in_a, to the right neighbour.
- out_b  out  LANES*DATA_WIDTH  registered in_b, to the bottom neighbour.
- load_bias  in  1  replace the accumulator with bias this cycle.
- bias  in  ACC_WIDTH  signed bias value.
- drain_load  in  1  capture the accumulator into the drain register and restart accumulation.
- drain_shift  in  1  drain register takes drain_in (column shift).
- drain_in  in  ACC_WIDTH  drain value from the PE above.
- drain_out  out  ACC_WIDTH  drain register contents.
- drain_ovf  out  1  overflow flag captured with the drain value.
- acc_out  out  ACC_WIDTH  live accumulator, for debug.

Behaviour:
- Reset (rst=0, asynchronous): acc, drain_reg, the sticky overflow flag, drain_ovf, out_valid, out_a and out_b all go to 0.
- en=0: all registers hold. This includes the forwarding registers. All other inputs are ignored.
- Forwarding (en=1): out_a<=in_a, out_b<=in_b and out_valid<=in_valid every cycle, independent of load/drain. Latency is 1 cycle.
- Lane product:
  - p_i = a_i*b_i, computed at 2*DW+1 bits with sign- or zero-extension per signed_mode.
  - p_i is forced to 0 if a_i==0 or b_i==0 (zero gating, multiplier inputs held at 0).
- Dot product: dot = sum of p_i over all lanes, sign-extended to ACC_WIDTH+1 bits. dot counts only if in_valid=1; otherwise dot=0.
- Accumulator next value (en=1), in priority order:
  1. drain_load=1: acc <= (load_bias ? bias : 0) + dot. drain_reg <= old acc. drain_ovf <= old sticky OR the overflow of this cycle's add. Sticky is cleared.
  2. load_bias=1: acc <= bias + dot; sticky is cleared.
  3. Otherwise: acc <= acc + dot.
- Saturation:
  - Every add is evaluated at ACC_WIDTH+1 bits.
  - If the result exceeds 2^(ACC_WIDTH-1)-1 or is below -2^(ACC_WIDTH-1), overflow=1.
  - SATURATE=1 clamps to the bound; SATURATE=0 keeps the low ACC_WIDTH bits.
  - overflow sets the sticky flag. Under priority 1 it goes directly to drain_ovf instead.
- Drain chain:
  - When drain_load=0 and drain_shift=1: drain_reg <= drain_in, and drain_ovf <= 0.
  - drain_load wins over drain_shift in the same cycle.
  - drain_shift with load_bias or accumulation in the same cycle is legal; the paths are independent.
- Outputs: drain_out=drain_reg and acc_out=acc, both purely registered, with no combinational path from inputs.
- Reset mid-tile: the partial sum and the drain contents are discarded; there is no recovery.
- Implementation: a single always_ff with asynchronous negedge rst; combinational lane logic in a generate loop.

Test Plan:
- Reset / forwarding: LANES=2, drive in_a=0x0302, in_b=0x0504, in_valid=1 with rst=0 → all outputs 0. Release rst → next edge gives out_a=0x0302, out_b=0x0504, out_valid=1; acc_out = 2*4+3*5 = 23.
- Bias merge and gating:
  - load_bias=1, bias=100 with a=(0,7), b=(9,2) → acc=114. The lane with a zero contributes nothing.
  - Next beat in_valid=0 → acc stays 114.
- Signed vs unsigned: a_0=0xFF, b_0=0x02, other lanes 0.
  - signed_mode=1 → dot=-2.
  - signed_mode=0 → dot=510.
- Saturation: SATURATE=1, bias=0x7FFFFFF0, then a=(127,127), b=(127,127) → acc=0x7FFFFFFF and the sticky flag is set. The next drain_load gives drain_out=0x7FFFFFFF and drain_ovf=1.
  - With SATURATE=0, the same stimulus wraps negative.
- Double-buffer drain: accumulate 50, then pulse drain_load with a valid beat of dot=6 → drain_out=50, acc=6. Three drain_shift cycles with drain_in=11,22,33 → drain_out=33 while acc keeps accumulating.
- Stall / priority:
  - en=0 for 4 cycles with all controls toggling → every output is frozen.
  - drain_load and drain_shift in the same cycle → drain_out=old acc, not drain_in.

Source files
------------

// File: rtl/pe_simd_drain.sv
// pe_simd_drain
// Systolic processing element for the Q-projection array. Each cycle it takes
// LANES operand pairs from the left/top neighbours, forwards them one cycle
// later, and accumulates their dot product into a saturating accumulator.
// A double-buffered drain register chained down the column lets the next tile
// accumulate while the previous result shifts out.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   en                global stall; 0 = every register holds
//   signed_mode       1 = operands signed, 0 = operands zero-extended
//   in_valid/in_a/in_b     operand beat; lane i at bits [i*DW +: DW]
//   out_valid/out_a/out_b  operand beat registered for the neighbours
//   load_bias, bias   replace accumulator with bias (merged with this beat)
//   drain_load        move accumulator into drain register, restart tile
//   drain_shift       drain register takes drain_in (column shift)
//   drain_in          drain value from the PE above
//   drain_out         drain register contents
//   drain_ovf         overflow flag captured with the drain value
//   acc_out           live accumulator (debug)
module pe_simd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 2,
    parameter int SATURATE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          signed_mode,
    input  logic                          in_valid,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    output logic                          out_valid,
    output logic [LANES*DATA_WIDTH-1:0]   out_a,
    output logic [LANES*DATA_WIDTH-1:0]   out_b,
    input  logic                          load_bias,
    input  logic [ACC_WIDTH-1:0]          bias,
    input  logic                          drain_load,
    input  logic                          drain_shift,
    input  logic [ACC_WIDTH-1:0]          drain_in,
    output logic [ACC_WIDTH-1:0]          drain_out,
    output logic                          drain_ovf,
    output logic [ACC_WIDTH-1:0]          acc_out
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW + 1;   // lane product width

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Registered state
    logic                        r_valid;
    logic [LANES*DW-1:0]         r_a;
    logic [LANES*DW-1:0]         r_b;
    logic [ACC_WIDTH-1:0]        r_acc;
    logic [ACC_WIDTH-1:0]        r_drain;
    logic                        r_drain_ovf;
    logic                        r_sticky;

    // Combinational datapath
    logic signed [PW-1:0]        w_prod [LANES];
    logic signed [ACC_WIDTH:0]   w_dot;
    logic        [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic                        w_ovf;
    logic        [ACC_WIDTH-1:0] w_acc_next;

    // Per-lane multiply. A zero operand forces both multiplier inputs to 0
    // so the multiplier does not toggle on sparse data.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic        [DW-1:0]   w_a_raw;
        logic        [DW-1:0]   w_b_raw;
        logic                   w_zero;
        logic signed [DW:0]     w_a_ext;
        logic signed [DW:0]     w_b_ext;
        logic signed [2*DW+1:0] w_full;

        assign w_a_raw = in_a[g*DW +: DW];
        assign w_b_raw = in_b[g*DW +: DW];
        assign w_zero  = (w_a_raw == '0) || (w_b_raw == '0);
        assign w_a_ext = w_zero ? '0 : {signed_mode & w_a_raw[DW-1], w_a_raw};
        assign w_b_ext = w_zero ? '0 : {signed_mode & w_b_raw[DW-1], w_b_raw};
        assign w_full  = w_a_ext * w_b_ext;
        // Full product always fits in 2*DW+1 bits for either operand mode.
        assign w_prod[g] = w_full[PW-1:0];
    end

    // Dot product, sign-extended to ACC_WIDTH+1; an invalid beat adds nothing.
    always_comb begin
        // NOTE: assign a default first so no path through the block leaves
        // w_dot unassigned and infers a latch.
        w_dot = '0;
        if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                w_dot = w_dot + (ACC_WIDTH+1)'(w_prod[i]);
            end
        end
    end

    // Addend base: drain_load restarts the tile (optionally from bias),
    // load_bias restarts from bias, otherwise keep accumulating.
    always_comb begin
        w_base = r_acc;
        if (drain_load) begin
            w_base = load_bias ? bias : '0;
        end else if (load_bias) begin
            w_base = bias;
        end
    end

    // One extra bit of headroom: the top two bits disagree exactly when the
    // result left the signed ACC_WIDTH range.
    assign w_sum = $signed({w_base[ACC_WIDTH-1], w_base}) + w_dot;
    assign w_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_acc_next = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_drain     <= '0;
            r_drain_ovf <= 1'b0;
            r_sticky    <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of r_acc/r_sticky regardless of statement order.
            r_valid <= in_valid;
            r_a     <= in_a;
            r_b     <= in_b;
            r_acc   <= w_acc_next;

            if (drain_load) begin
                // Old accumulator moves to the drain buffer; this cycle's
                // overflow belongs to the finished tile's flag.
                r_drain     <= r_acc;
                r_drain_ovf <= r_sticky | w_ovf;
                r_sticky    <= 1'b0;
            end else begin
                if (drain_shift) begin
                    r_drain     <= drain_in;
                    r_drain_ovf <= 1'b0;
                end
                r_sticky <= load_bias ? w_ovf : (r_sticky | w_ovf);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign acc_out   = r_acc;
    assign drain_out = r_drain;
    assign drain_ovf = r_drain_ovf;

endmodule

// File: tb/tb_pe_simd_drain.sv
// tb_pe_simd_drain
// Directed bench for pe_simd_drain (LANES=2, DW=8, ACC=32). Two instances share
// the stimulus: one saturating, one wrapping. Inputs change #1 after the
// rising edge and outputs are sampled there as well.
module tb_pe_simd_drain;

    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int LN  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              signed_mode;
    logic              in_valid;
    logic [LN*DW-1:0]  in_a;
    logic [LN*DW-1:0]  in_b;
    logic              load_bias;
    logic [AW-1:0]     bias;
    logic              drain_load;
    logic              drain_shift;
    logic [AW-1:0]     drain_in;

    logic              out_valid_s, out_valid_w;
    logic [LN*DW-1:0]  out_a_s, out_a_w, out_b_s, out_b_w;
    logic [AW-1:0]     drain_out_s, drain_out_w, acc_out_s, acc_out_w;
    logic              drain_ovf_s, drain_ovf_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pe_simd_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(LN), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_s), .out_a(out_a_s), .out_b(out_b_s),
        .load_bias(load_bias), .bias(bias),
        .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(drain_in),
        .drain_out(drain_out_s), .drain_ovf(drain_ovf_s), .acc_out(acc_out_s)
    );

    pe_simd_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(LN), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_w), .out_a(out_a_w), .out_b(out_b_w),
        .load_bias(load_bias), .bias(bias),
        .drain_load(drain_load), .drain_shift(drain_shift), .drain_in(drain_in),
        .drain_out(drain_out_w), .drain_ovf(drain_ovf_w), .acc_out(acc_out_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land #1 past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        load_bias   = 1'b0;
        drain_load  = 1'b0;
        drain_shift = 1'b0;
        in_valid    = 1'b0;
    endtask

    // Load the accumulator with a bias merged with one lane-0 product.
    task automatic bias_beat(input logic [AW-1:0] b_val, input logic [7:0] a0, input logic [7:0] b0);
        idle_ctrl();
        load_bias = 1'b1;
        bias      = b_val;
        in_valid  = 1'b1;
        in_a      = {8'd0, a0};
        in_b      = {8'd0, b0};
        step();
    endtask

    initial begin
        // Reset with a live beat on the inputs.
        rst = 1'b0; en = 1'b1; signed_mode = 1'b0;
        idle_ctrl();
        bias = '0; drain_in = '0;
        in_valid = 1'b1; in_a = 16'h0302; in_b = 16'h0504;
        #12;
        check("rst_out_a",     64'(out_a_s),     64'h0);
        check("rst_out_b",     64'(out_b_s),     64'h0);
        check("rst_out_valid", 64'(out_valid_s), 64'h0);
        check("rst_acc",       64'(acc_out_s),   64'h0);
        check("rst_drain",     64'(drain_out_s), 64'h0);
        check("rst_ovf",       64'(drain_ovf_s), 64'h0);

        // Forwarding and first accumulation: 2*4 + 3*5 = 23.
        rst = 1'b1;
        step();
        check("fwd_out_a",     64'(out_a_s),     64'h0302);
        check("fwd_out_b",     64'(out_b_s),     64'h0504);
        check("fwd_out_valid", 64'(out_valid_s), 64'h1);
        check("fwd_acc",       64'(acc_out_s),   64'd23);

        // Bias merge with a zero-gated lane: 100 + 0*9 + 7*2 = 114.
        load_bias = 1'b1; bias = 32'd100;
        in_a = 16'h0700; in_b = 16'h0209;
        step();
        check("bias_merge_acc", 64'(acc_out_s), 64'd114);
        idle_ctrl();
        step();
        check("invalid_hold_acc", 64'(acc_out_s), 64'd114);
        check("invalid_out_valid", 64'(out_valid_s), 64'h0);

        // Signed vs unsigned: 0xFF * 2.
        signed_mode = 1'b1;
        bias_beat(32'd0, 8'hFF, 8'h02);
        check("signed_dot", 64'(acc_out_s), 64'hFFFF_FFFE);
        signed_mode = 1'b0;
        bias_beat(32'd0, 8'hFF, 8'h02);
        check("unsigned_dot", 64'(acc_out_s), 64'd510);

        // Double-buffer drain: accumulate 50, then drain with a dot=6 beat.
        bias_beat(32'd0, 8'd5, 8'd10);
        check("acc_50", 64'(acc_out_s), 64'd50);
        idle_ctrl();
        drain_load = 1'b1; in_valid = 1'b1;
        in_a = 16'h0002; in_b = 16'h0003;
        step();
        check("drain_load_out", 64'(drain_out_s), 64'd50);
        check("drain_load_acc", 64'(acc_out_s),   64'd6);
        check("drain_load_ovf", 64'(drain_ovf_s), 64'h0);
        drain_load = 1'b0; drain_shift = 1'b1;
        in_a = 16'h0001; in_b = 16'h0001;
        for (int i = 1; i <= 3; i++) begin
            drain_in = 32'(11 * i);
            step();
            check("shift_drain", 64'(drain_out_s), 64'(11 * i));
            check("shift_acc",   64'(acc_out_s),   64'(6 + i));
        end

        // Stall: everything toggles, nothing moves.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_bias   = i[0];
            drain_load  = ~i[0];
            drain_shift = i[1];
            in_valid    = ~i[1];
            signed_mode = i[0];
            in_a        = 16'hA5A5 ^ 16'(i);
            in_b        = 16'h5A5A ^ 16'(i);
            bias        = 32'h1234_0000 + 32'(i);
            drain_in    = 32'hDEAD_0000 + 32'(i);
            if (i == 3) rst = 1'b1;
            step();
            check("stall_out_a",     64'(out_a_s),     64'h0001);
            check("stall_out_b",     64'(out_b_s),     64'h0001);
            check("stall_out_valid", 64'(out_valid_s), 64'h1);
            check("stall_acc",       64'(acc_out_s),   64'd9);
            check("stall_drain",     64'(drain_out_s), 64'd33);
            check("stall_ovf",       64'(drain_ovf_s), 64'h0);
        end
        en = 1'b1; signed_mode = 1'b0;

        // drain_load beats drain_shift.
        idle_ctrl();
        drain_load = 1'b1; drain_shift = 1'b1; drain_in = 32'd77;
        step();
        check("prio_drain", 64'(drain_out_s), 64'd9);
        check("prio_acc",   64'(acc_out_s),   64'd0);

        // Positive saturation vs wrap.
        idle_ctrl();
        load_bias = 1'b1; bias = 32'h7FFF_FFF0;
        step();
        check("sat_preload", 64'(acc_out_s), 64'h7FFF_FFF0);
        idle_ctrl();
        signed_mode = 1'b1; in_valid = 1'b1;
        in_a = 16'h7F7F; in_b = 16'h7F7F;
        step();
        check("sat_pos_acc",  64'(acc_out_s), 64'h7FFF_FFFF);
        check("wrap_pos_acc", 64'(acc_out_w), 64'h8000_7DF2);
        idle_ctrl();
        drain_load = 1'b1;
        step();
        check("sat_pos_drain",  64'(drain_out_s), 64'h7FFF_FFFF);
        check("sat_pos_ovf",    64'(drain_ovf_s), 64'h1);
        check("wrap_pos_drain", 64'(drain_out_w), 64'h8000_7DF2);
        check("wrap_pos_ovf",   64'(drain_ovf_w), 64'h1);
        // Sticky flag was consumed by the previous drain.
        step();
        check("sticky_cleared", 64'(drain_ovf_s), 64'h0);
        check("drain_zero",     64'(drain_out_s), 64'h0);

        // Negative saturation, overflow on a bias-load beat: MIN + (-2).
        bias_beat(32'h8000_0000, 8'hFF, 8'h02);
        check("sat_neg_acc",  64'(acc_out_s), 64'h8000_0000);
        check("wrap_neg_acc", 64'(acc_out_w), 64'h7FFF_FFFE);
        idle_ctrl();
        drain_load = 1'b1;
        step();
        check("sat_neg_ovf",  64'(drain_ovf_s), 64'h1);
        check("sat_neg_drain", 64'(drain_out_s), 64'h8000_0000);

        // Mid-tile reset discards everything.
        idle_ctrl();
        bias_beat(32'd40, 8'd1, 8'd2);
        #2 rst = 1'b0;
        #1;
        check("midrst_acc",   64'(acc_out_s),   64'h0);
        check("midrst_drain", 64'(drain_out_s), 64'h0);
        check("midrst_valid", 64'(out_valid_s), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
